// File: rtl/freq_div_pkg.sv
// Shared types and constants for the time-shared clock divider controller.
// The divider is a free-running counter; tap k of it is a divide-by-2^(k+1) clock.
package freq_div_pkg;

  localparam int FD_CW   = 8;
  localparam int FD_SELW = $clog2(FD_CW);

  // Tap-to-ratio table for the default 8-bit counter:
  //   sel 0 -> /2    sel 1 -> /4    sel 2 -> /8    sel 3 -> /16
  //   sel 4 -> /32   sel 5 -> /64   sel 6 -> /128  sel 7 -> /256
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/freq_div_sched_rr_arbiter.sv
// Round-robin picker: the first active request at or after ptr (mod NREQ) wins.
// Purely combinational; the caller owns the pointer register.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   idx,
  output logic            valid
);

  localparam int KW = PW + 1;

  logic [2*NREQ-1:0] req2;
  logic [NREQ-1:0]   rot;
  logic [KW-1:0]     k;
  logic [KW-1:0]     sum;

  always_comb begin
    req2  = {req, req};
    rot   = NREQ'(req2 >> ptr);
    k     = '0;
    valid = 1'b0;
    // Scan downward so the lowest set bit of the rotated vector wins.
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        k     = KW'(i);
        valid = 1'b1;
      end
    end
    sum = {1'b0, ptr} + k;
    if (sum >= KW'(NREQ)) begin
      sum = sum - KW'(NREQ);
    end
    idx = sum[PW-1:0];
    gnt = valid ? (NREQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/freq_div_sched.sv
// Shares one divider counter among NREQ requesters; ownership changes only at
// counter wrap so div_out never glitches or emits a runt pulse on hand-over.
module freq_div_sched
  import freq_div_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int CW   = FD_CW,
  parameter int SELW = $clog2(CW)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*SELW-1:0] sel_in,
  output logic [NREQ-1:0]   gnt,
  output logic [SELW-1:0]   cur_sel,
  output logic              div_out,
  output logic              busy,
  output logic [1:0]        dbg_state,
  output logic [CW-1:0]     dbg_cnt
);

  // Handshake: req is a level held high while the divider is wanted; gnt is
  // the registered one-hot answer. Dropping req releases ownership, and the
  // release only completes at the next counter wrap.

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CW-1:0] CNT_MAX = '1;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic            div_q, div_d;
  logic            busy_q, busy_d;

  logic [NREQ-1:0] arb_gnt;
  logic [PW-1:0]   arb_idx;
  logic            arb_valid;
  logic            owner_req;
  logic            at_wrap;
  logic            take_grant;

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .req   (req),
    .ptr   (ptr_q),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      div_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      div_q   <= div_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gnt_d      = gnt_q;
    sel_d      = sel_q;
    ptr_d      = ptr_q;
    take_grant = 1'b0;
    at_wrap    = (cnt_q == CNT_MAX);
    owner_req  = |(req & gnt_q);

    case (state_q)
      ST_IDLE: begin
        cnt_d      = '0;
        take_grant = arb_valid;
      end
      ST_RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (!owner_req) begin
          gnt_d = '0;
          if (at_wrap) begin
            take_grant = arb_valid;
            state_d    = ST_IDLE;
          end else begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        cnt_d = cnt_q + CW'(1);
        if (at_wrap) begin
          take_grant = arb_valid;
          state_d    = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        gnt_d   = '0;
      end
    endcase

    // A grant always lands with the counter at 0, so the new owner starts on
    // a clean low phase whatever its ratio.
    if (take_grant) begin
      state_d = ST_RUN;
      cnt_d   = '0;
      gnt_d   = arb_gnt;
      sel_d   = sel_in[int'(arb_idx)*SELW +: SELW];
      ptr_d   = (arb_idx == PW'(NREQ - 1)) ? '0 : arb_idx + PW'(1);
    end
  end

  // div_out is taken from the next counter value so the output is a flop.
  always_comb begin
    div_d  = cnt_d[sel_d];
    busy_d = (state_d != ST_IDLE);
  end

  assign gnt       = gnt_q;
  assign cur_sel   = sel_q;
  assign div_out   = div_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;
  assign dbg_cnt   = cnt_q;

endmodule

// File: tb/tb_freq_div_sched.sv
// Directed scenarios followed by random traffic, all checked against an
// arithmetic reference model of the shared divider.
module tb_freq_div_sched;

  localparam int NREQ = 2;
  localparam int CW   = 8;
  localparam int SELW = 3;
  localparam int W    = NREQ + SELW + 2;

  logic                 clk;
  logic                 reset;
  logic [NREQ-1:0]      req;
  logic [NREQ*SELW-1:0] sel_in;
  logic [NREQ-1:0]      gnt;
  logic [SELW-1:0]      cur_sel;
  logic                 div_out;
  logic                 busy;
  logic [1:0]           dbg_state;
  logic [CW-1:0]        dbg_cnt;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_q[$];

  // Reference model: owner index (-1 none), phase count, latched ratio, pointer.
  int m_owner;
  int m_cnt;
  int m_sel;
  int m_ptr;
  bit m_busy;

  freq_div_sched #(
    .NREQ (NREQ),
    .CW   (CW),
    .SELW (SELW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .sel_in    (sel_in),
    .gnt       (gnt),
    .cur_sel   (cur_sel),
    .div_out   (div_out),
    .busy      (busy),
    .dbg_state (dbg_state),
    .dbg_cnt   (dbg_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int start);
    for (int i = 0; i < NREQ; i++) begin
      int j;
      j = (start + i) % NREQ;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_cnt   = 0;
    m_sel   = 0;
    m_ptr   = 0;
    m_busy  = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_grant_or_idle();
    int w;
    w = rr_pick(req, m_ptr);
    m_cnt = 0;
    if (w >= 0) begin
      m_owner = w;
      m_sel   = int'(sel_in[w*SELW +: SELW]);
      m_ptr   = (w + 1) % NREQ;
      m_busy  = 1'b1;
    end else begin
      m_owner = -1;
      m_busy  = 1'b0;
    end
  endtask

  task automatic model_step();
    logic [NREQ-1:0] e_gnt;
    bit              e_div;
    if (!m_busy) begin
      model_grant_or_idle();
    end else if (m_owner >= 0 && req[m_owner]) begin
      m_cnt = (m_cnt + 1) % 256;
    end else if (m_cnt == 255) begin
      model_grant_or_idle();
    end else begin
      m_owner = -1;
      m_cnt   = m_cnt + 1;
    end
    e_gnt = (m_owner >= 0) ? NREQ'(1 << m_owner) : '0;
    e_div = m_busy ? bit'((m_cnt >> m_sel) & 1) : 1'b0;
    exp_q.push_back({e_gnt, SELW'(m_sel), e_div, m_busy});
  endtask

  task automatic check_outputs();
    logic [W-1:0] e;
    e = exp_q.pop_front();
    chk("gnt", 32'(gnt), 32'(e[W-1 -: NREQ]));
    chk("cur_sel", 32'(cur_sel), 32'(e[SELW+1 -: SELW]));
    chk("div_out", 32'(div_out), 32'(e[1]));
    chk("busy", 32'(busy), 32'(e[0]));
    chk("count", 32'(dbg_cnt), 32'(m_cnt));
    chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic set_sel(input int i, input int v);
    sel_in[i*SELW +: SELW] = SELW'(v);
  endtask

  task automatic wait_cnt(input string tag, input int target);
    int n;
    n = 0;
    while (m_cnt != target && n < 600) begin
      cyc();
      n++;
    end
    chk(tag, 32'(n < 600), 32'd1);
  endtask

  initial begin
    int n;
    reset  = 1'b0;
    req    = '0;
    sel_in = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_gnt", 32'(gnt), 32'd0);
    chk("reset_div", 32'(div_out), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_sel", 32'(cur_sel), 32'd0);
    reset = 1'b1;
    run(2);

    // Single owner at /2.
    req = 2'b01;
    set_sel(0, 0);
    cyc();
    chk("s1_gnt", 32'(gnt), 32'b01);
    chk("s1_busy", 32'(busy), 32'd1);
    cyc();
    chk("s1_first_high", 32'(div_out), 32'd1);
    run(10);

    // Owner at /8 drops at count 100 and drains to idle.
    req = '0;
    n = 0;
    while (m_busy && n < 600) begin cyc(); n++; end
    chk("s2_idle_wait", 32'(n < 600), 32'd1);
    req = 2'b01;
    set_sel(0, 2);
    cyc();
    wait_cnt("s2_wait100", 100);
    req = '0;
    cyc();
    chk("s2_gnt_drop", 32'(gnt), 32'd0);
    chk("s2_busy_drain", 32'(busy), 32'd1);
    wait_cnt("s2_wait255", 255);
    cyc();
    chk("s2_idle_busy", 32'(busy), 32'd0);
    chk("s2_idle_div", 32'(div_out), 32'd0);

    // Fresh pointer: both request, 0 wins at /4, then hands to 1 at /256.
    reset = 1'b0;
    model_reset();
    #3;
    reset = 1'b1;
    req = 2'b11;
    set_sel(0, 1);
    set_sel(1, 7);
    cyc();
    chk("s3_gnt0", 32'(gnt), 32'b01);
    chk("s3_sel0", 32'(cur_sel), 32'd1);
    run(20);
    req = 2'b10;
    n = 0;
    while (m_owner != 1 && n < 600) begin cyc(); n++; end
    chk("s3_handover_wait", 32'(n < 600), 32'd1);
    chk("s3_gnt1", 32'(gnt), 32'b10);
    chk("s3_sel1", 32'(cur_sel), 32'd7);
    run(260);

    // Owner's later select changes are ignored.
    req = '0;
    n = 0;
    while (m_busy && n < 600) begin cyc(); n++; end
    chk("s4_idle_wait", 32'(n < 600), 32'd1);
    req = 2'b10;
    set_sel(1, 3);
    cyc();
    chk("s4_sel3", 32'(cur_sel), 32'd3);
    run(5);
    set_sel(1, 0);
    run(40);
    chk("s4_sel_kept", 32'(cur_sel), 32'd3);

    // Owner drops exactly at the wrap edge with requester 0 pending.
    set_sel(0, 0);
    req = 2'b11;
    wait_cnt("s5_wait255", 255);
    req = 2'b01;
    cyc();
    chk("s5_direct_gnt", 32'(gnt), 32'b01);
    chk("s5_cnt0", 32'(dbg_cnt), 32'd0);
    chk("s5_busy", 32'(busy), 32'd1);

    // Asynchronous reset in the middle of a high phase.
    wait_cnt("s6_wait37", 37);
    chk("s6_div_high", 32'(div_out), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("s6_async_div", 32'(div_out), 32'd0);
    chk("s6_async_gnt", 32'(gnt), 32'd0);
    chk("s6_async_busy", 32'(busy), 32'd0);
    chk("s6_async_cnt", 32'(dbg_cnt), 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    cyc();
    chk("s6_regrant", 32'(gnt), 32'b01);
    chk("s6_cnt_restart", 32'(dbg_cnt), 32'd0);

    // Random traffic with jittering selects.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 39) == 0) req = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) set_sel(i, int'($urandom_range(0, 7)));
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/freq_div_sched.md
Name: freq_div_sched

Overview:
Controller that shares one 8-bit divide-by-2^(k+1) counter between NREQ requesters, each wanting its own division factor. It arbitrates round-robin and grants the divider to one requester at a time. Hand-over is allowed only at counter wrap (all taps low), so the divided clock never glitches or produces a runt pulse across a change of owner or factor. It sits between the clock-consuming blocks and the divider datapath, which it owns internally.

Parameters:
NREQ, 2, number of requesters (legal 2..8)
CW, 8, divider counter width; tap k gives divide-by-2^(k+1)
SELW, $clog2(CW) = 3, width of each select field

Ports:
clk  input  1  system clock; all state updates on posedge
reset  input  1  asynchronous, active-low reset
req  input  NREQ  per-requester request level; held high while divider is wanted
sel_in  input  NREQ*SELW  packed selects, requester i at [i*SELW +: SELW]; 0 = /2 ... 7 = /256
gnt  output  NREQ  one-hot registered grant; all-zero when no owner
cur_sel  output  SELW  select currently driving div_out
div_out  output  1  registered divided clock
busy  output  1  high in RUN or DRAIN

Behaviour:
- Reset (async, reset=0): state=IDLE, counter=0, gnt=0, cur_sel=0, div_out=0, busy=0, rr pointer=0. Outputs drop immediately, mid-period included.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - counter held at 0, div_out=0.
  - If any req is high at edge E: at E, gnt=winner, cur_sel=sel_in[winner], state=RUN, counter=0.
  - Counting starts at E+1.
- RUN:
  - counter increments every edge, wrapping 255->0.
  - div_out is registered and equals counter[cur_sel] after each edge (computed from the next counter value, no combinational mux on the output).
  - Owner's sel_in is sampled only at grant. Later changes are ignored until a new grant.
  - Owner req low at edge with counter!=255: gnt=0, state=DRAIN, counter keeps running.
- DRAIN: counter runs until the edge where counter==255 (wrap point).
- Wrap-point arbitration. At an edge in DRAIN with counter==255, or in RUN with counter==255 and owner req low:
  - counter->0, div_out->0.
  - If any req is high, the round-robin winner takes the grant at that same edge: gnt and cur_sel update, state=RUN.
  - Otherwise state=IDLE.
  - Hand-over gap is 0 cycles. Worst-case grant latency is 256 cycles.
- Owner holding req in RUN keeps the grant indefinitely. No pre-emption.
- Round-robin: search starts at (last granted index + 1) mod NREQ. The pointer updates on every grant.
- An owner that drops and re-raises req before wrap is treated as a new request and ranks last.
- sel_in of non-granted requesters is ignored.
- busy = (state != IDLE), registered.
- Invariants:
  - gnt is one-hot or zero.
  - gnt!=0 implies state==RUN.
  - cur_sel changes only on an edge where counter becomes 0.

Decomposition:
- Package freq_div_pkg: state enum {IDLE, RUN, DRAIN}, CW and SELW constants, tap-to-ratio comment table.
- One sub-module, rr_arbiter (req vector + pointer -> one-hot winner + valid), is natural and reusable.
- Counter, FSM and output register stay in freq_div_sched.

Test Plan:
- Reset then req=01, sel0=0 -> gnt=01 one edge later, busy=1; div_out toggles every cycle (/2), first high one edge after counting starts.
- Owner 0 (sel=2) drops req at counter=100 -> gnt=00 next edge, div_out keeps /8 pattern until counter 255->0, then state=IDLE, div_out=0, busy=0.
- req=11, sel0=1, sel1=7, pointer=0 -> requester 0 granted (/4). Req0 drops -> at wrap gnt=10 same edge, cur_sel=7, div_out low for 128 cycles, then high for 128. No runt pulse at the switch.
- Owner changes sel_in from 3 to 0 while granted -> cur_sel stays 3, div_out period stays 16 cycles.
- Owner req drops on the exact edge counter==255 with req1 pending -> direct hand-over at that edge, no DRAIN cycles.
- Assert reset mid-RUN at counter=37, div_out=1 -> div_out, gnt, busy go 0 without a clock. After release with req held -> fresh grant, counter restarts at 0.
